// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the mode encoding
// used by the top level and by every stage.
package usr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_stage.sv
// One lane-word stage of the universal shift register: a WIDTH-bit register
// whose next value is chosen from itself, either neighbour or a load slice.
module usr_stage
  import usr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_left,
  input  logic [WIDTH-1:0] i_right,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // i_left feeds a right shift, i_right feeds a left shift.
  always_comb begin
    w_next = r_q;
    unique case (i_mode)
      MODE_HOLD: w_next = r_q;
      MODE_SHR:  w_next = i_left;
      MODE_SHL:  w_next = i_right;
      MODE_LOAD: w_next = i_load;
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_shift_reg.sv
// DEPTH-stage, WIDTH-bit universal shift register (hold / shift right /
// shift left / parallel load) with a saturating fill counter and full flag.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  mode_t                  mode,
  input  logic [WIDTH-1:0]       si_left,
  input  logic [WIDTH-1:0]       si_right,
  input  logic [WIDTH*DEPTH-1:0] pin,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [WIDTH-1:0]       so_right,
  output logic [WIDTH-1:0]       so_left,
  output logic [CNT_W-1:0]       count,
  output logic                   full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] w_stage [DEPTH];
  logic [CNT_W-1:0] r_count;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] w_left;
      logic [WIDTH-1:0] w_right;

      // The chain ends take the serial inputs instead of a neighbour.
      if (gi == DEPTH-1) begin : g_top
        assign w_left = si_left;
      end else begin : g_mid_l
        assign w_left = w_stage[gi+1];
      end
      if (gi == 0) begin : g_bot
        assign w_right = si_right;
      end else begin : g_mid_r
        assign w_right = w_stage[gi-1];
      end

      usr_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_en    (en),
        .i_mode  (mode),
        .i_left  (w_left),
        .i_right (w_right),
        .i_load  (pin[gi*WIDTH +: WIDTH]),
        .o_q     (w_stage[gi])
      );

      assign pout[gi*WIDTH +: WIDTH] = w_stage[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      unique case (mode)
        MODE_SHR, MODE_SHL: begin
          if (r_count != FULL_CNT) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        MODE_LOAD: r_count <= FULL_CNT;
        default:   r_count <= r_count;
      endcase
    end
  end

  assign so_right = w_stage[0];
  assign so_left  = w_stage[DEPTH-1];
  assign count    = r_count;
  assign full     = (r_count == FULL_CNT);

endmodule
